// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer around one external 1-bit full adder.
// Each RUN cycle presents one operand bit pair and the registered carry to the cell,
// then captures its sum and carry-out. The result lands WIDTH edges after start.
// Optional feature: define SERIAL_ADD_SUB_EN to add a 'sub' port (a - b via ~b + 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q, cout_q;
    logic [WIDTH-1:0]   sum_q;

    logic               load;
    logic               last;
    logic [WIDTH-1:0]   b_ld_d;
    logic               c_ld_d;

    assign load = start && (state_q != RUN);
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    // Operand B and initial carry as loaded; subtraction is a + ~b + 1
    always_comb begin
        b_ld_d = b;
        c_ld_d = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_ld_d = ~b;
            c_ld_d = 1'b1;
        end
`endif
    end

    // Sequencer: load on start, shift one bit per RUN edge, publish on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else if (load) begin
            // IDLE or DONE with start: DONE reloads directly, no idle bubble
            state_q  <= RUN;
            a_sh_q   <= a;
            b_sh_q   <= b_ld_d;
            res_sh_q <= '0;
            carry_q  <= c_ld_d;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (state_q == RUN) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            res_sh_q <= {fa_s, res_sh_q[WIDTH-1:1]};
            carry_q  <= fa_cout;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
                state_q <= DONE;
                sum_q   <= {fa_s, res_sh_q[WIDTH-1:1]};
                cout_q  <= fa_cout;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else begin
            // IDLE without start, or the single DONE cycle expiring
            state_q <= IDLE;
            done_q  <= 1'b0;
        end
    end

    // Cell inputs come straight from registers so the external cell cannot close a loop
    assign fa_a = (state_q == RUN) & a_sh_q[0];
    assign fa_b = (state_q == RUN) & b_sh_q[0];
    assign fa_c = (state_q == RUN) & carry_q;

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full-adder cell.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         fa_a, fa_b, fa_c, fa_s, fa_cout;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub = 1'b0;
`endif

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // The external 1-bit full adder cell
    assign fa_s    = fa_a ^ fa_b ^ fa_c;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    serial_add_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_c    (fa_c),
        .fa_s    (fa_s),
        .fa_cout (fa_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: start edge, WIDTH RUN edges, one DONE cycle, then idle.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic tsub,
                          input logic [W-1:0] es, input logic ec);
        logic [W-1:0] prev_sum;
        logic [W-1:0] bb;
        prev_sum = sum;
        bb = tsub ? ~tb_ : tb_;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = tsub;
`endif
        step();
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk({tag, "_busy"}, {busy, done}, 2'b10);
            chk({tag, "_fa_ab"}, {fa_a, fa_b}, {ta[k], bb[k]});
            chk({tag, "_hold"}, sum, prev_sum);
            step();
        end
        chk({tag, "_done"}, {busy, done}, 2'b01);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        step();
        chk({tag, "_idle"}, {busy, done, fa_a, fa_b, fa_c}, 5'b0);
        chk({tag, "_keep"}, {cout, sum}, {ec, es});
    endtask

    initial begin
        logic saw;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        step(); step();
        chk("rst_state", {busy, done, cout, sum}, '0);
        chk("rst_fa", {fa_a, fa_b, fa_c}, 3'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_hold", {busy, done}, 2'b0);

        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("addff_00c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        run_op("addaa_55c", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1);
        run_op("add0f_f0", 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0);

        // Back-to-back: start held through DONE reloads without an idle cycle
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        step();
        a = 8'h01; b = 8'h01;          // seen only at the DONE reload
        repeat (W - 1) step();
        chk("b2b_busy1", {busy, done}, 2'b10);
        step();
        chk("b2b_done1", {done, sum, cout}, {1'b1, 8'h46, 1'b0});
        step();
        start = 1'b0;
        chk("b2b_reload", {busy, done, sum}, {2'b10, 8'h46});
        repeat (W - 1) step();
        chk("b2b_hold", {done, sum}, {1'b0, 8'h46});
        step();
        chk("b2b_done2", {done, sum, cout}, {1'b1, 8'h02, 1'b0});
        step();
        chk("b2b_end", {busy, done}, 2'b0);

        // Start during RUN is ignored; operands are not re-sampled
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        a = 8'hAA; b = 8'hAA; start = 1'b1;
        step();
        start = 1'b0;
        repeat (W - 5) step();
        chk("ign_pre", {busy, done}, 2'b10);
        step();
        chk("ign_done", {done, sum, cout}, {1'b1, 8'h10, 1'b0});
        step();
        chk("ign_idle", {busy, done}, 2'b0);

        // Reset mid-RUN discards the partial result and suppresses done
        @(negedge clk);
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst", {busy, done, cout, sum}, '0);
        chk("mid_rst_fa", {fa_a, fa_b, fa_c}, 3'b0);
        saw = 1'b0;
        repeat (12) begin
            step();
            if (done || busy) saw = 1'b1;
        end
        chk("mid_rst_quiet", saw, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
        run_op("add_nosub", 8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
